counter_arbiter: RTL

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that grants a counted window of len cycles
// and keeps a sticky flag whenever a window runs through the full counter range.
module counter_arbiter #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [CW-1:0] len0,
    input  logic [CW-1:0] len1,
    input  logic          pause,
    input  logic          clr_ovf,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [CW-1:0] counter_out,
    output logic [1:0]    done,
    output logic          overflow_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          winner;
    logic          winner_nxt;
    logic          last;
    logic          last_nxt;
    logic          pick;
    logic [CW-1:0] len_sel;
    logic [CW-1:0] target;
    logic [CW-1:0] target_nxt;
    logic [CW-1:0] counter_nxt;
    logic [1:0]    gnt_nxt;
    logic [1:0]    done_nxt;
    logic          busy_nxt;
    logic          ovf_nxt;
    logic          at_target;
    logic          ovf_set;

    // A lone request always wins; a tie goes to whoever was not served last.
    always_comb begin
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            default: pick = ~last;
        endcase
        len_sel = pick ? len1 : len0;
    end

    assign at_target = (counter_out == target);
    assign ovf_set   = (state == RUN) && !pause && (counter_out == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = RUN;
            RUN:     if (!pause && at_target) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt     = gnt;
        done_nxt    = '0;
        busy_nxt    = (state_nxt != IDLE);
        counter_nxt = counter_out;
        target_nxt  = target;
        winner_nxt  = winner;
        last_nxt    = last;
        // Set takes priority over a simultaneous clear.
        ovf_nxt     = ovf_set | (overflow_out & ~clr_ovf);
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (|req) begin
                    winner_nxt  = pick;
                    gnt_nxt     = pick ? 2'b10 : 2'b01;
                    counter_nxt = '0;
                    // len of 0 wraps to a target of all ones: a full-range window.
                    target_nxt  = len_sel - CW'(1);
                end
            end
            RUN: begin
                if (!pause) begin
                    if (at_target) begin
                        gnt_nxt  = '0;
                        done_nxt = winner ? 2'b10 : 2'b01;
                    end else begin
                        counter_nxt = counter_out + CW'(1);
                    end
                end
            end
            FINISH: begin
                gnt_nxt  = '0;
                last_nxt = winner;
            end
            default: begin
                gnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt          <= '0;
            done         <= '0;
            busy         <= 1'b0;
            counter_out  <= '0;
            overflow_out <= 1'b0;
            target       <= '0;
            winner       <= 1'b0;
            last         <= 1'b1;
        end else begin
            gnt          <= gnt_nxt;
            done         <= done_nxt;
            busy         <= busy_nxt;
            counter_out  <= counter_nxt;
            overflow_out <= ovf_nxt;
            target       <= target_nxt;
            winner       <= winner_nxt;
            last         <= last_nxt;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(done));

endmodule
